// File: rtl/deparser_chain_pkg.sv
// deparser_pkg: shared types and constants for the deparser chain.
//   Head/meta/tag widths, tag bit positions, local register bank layout,
//   read FSM state type and a saturating counter helper.
package deparser_pkg;

  localparam int unsigned HEAD_WIDTH    = 64;
  localparam int unsigned META_WIDTH    = 32;
  localparam int unsigned TAG_WIDTH     = 8;
  // Tag occupies the low TAG_WIDTH bits of every head/meta word.
  localparam int unsigned TAG_VALID_BIT = 0;
  localparam int unsigned TAG_START_BIT = 1;

  localparam logic [7:0]  LOCAL_LAYER_ID = 8'hFF;
  localparam logic [31:0] BAD_RDATA      = 32'hDEADBEEF;

  localparam logic [1:0] WORD_VERSION = 2'd0;
  localparam logic [1:0] WORD_NLAYER  = 2'd1;
  localparam logic [1:0] WORD_PKTCNT  = 2'd2;
  localparam logic [1:0] WORD_ERRCNT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } rd_state_e;

  // 32-bit add of a small increment, clamped at all-ones.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
    logic [32:0] s;
    s = {1'b0, a} + 33'(inc);
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/deparser_chain_if.sv
// deparser_chain_if: rule access bus of the deparser chain.
//   master : host side (drives strobes/address/data, receives read data/busy)
//   slave  : deparser side
interface deparser_chain_if;
  logic        i_rule_wren;
  logic        i_rule_rden;
  logic [31:0] i_rule_addr;
  logic [31:0] i_rule_wdata;
  logic        o_rule_rdata_valid;
  logic [31:0] o_rule_rdata;
  logic        o_rule_busy;

  modport master (
    output i_rule_wren, i_rule_rden, i_rule_addr, i_rule_wdata,
    input  o_rule_rdata_valid, o_rule_rdata, o_rule_busy
  );

  modport slave (
    input  i_rule_wren, i_rule_rden, i_rule_addr, i_rule_wdata,
    output o_rule_rdata_valid, o_rule_rdata, o_rule_busy
  );
endinterface

// File: rtl/deparser_chain_rule_ctrl.sv
// deparser_rule_ctrl: rule bus front end of the deparser chain.
//   rule_bus      : host rule bus (slave side)
//   o_layer_*     : registered write/read strobes (one-hot per layer), address, data
//   i_layer_*     : per-layer read responses
//   i_pkt_start   : chain output carries a valid start-of-packet slice
// Holds the single-outstanding read FSM with timeout and the local bank at
// layer ID 0xFF (version, layer count, packet and error counters).
module deparser_rule_ctrl
  import deparser_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 3,
  parameter int unsigned RD_TIMEOUT = 16,
  parameter logic [31:0] VERSION    = 32'h0002_0000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  deparser_chain_if.slave       rule_bus,
  output logic [NUM_LAYERS-1:0] o_layer_wren,
  output logic [NUM_LAYERS-1:0] o_layer_rden,
  output logic [23:0]           o_layer_addr,
  output logic [31:0]           o_layer_wdata,
  input  logic [NUM_LAYERS-1:0] i_layer_rdata_valid,
  input  logic [31:0]           i_layer_rdata [NUM_LAYERS],
  input  logic                  i_pkt_start
);

  localparam int unsigned     TIMER_W    = $clog2(RD_TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(RD_TIMEOUT - 1);
  localparam logic [7:0]      NL8        = 8'(NUM_LAYERS);

  logic [7:0]  cmd_id;
  logic [1:0]  local_word;
  logic        id_is_layer;
  logic        id_is_local;

  assign cmd_id      = rule_bus.i_rule_addr[31:24];
  assign local_word  = rule_bus.i_rule_addr[3:2];
  assign id_is_layer = 32'(cmd_id) < NUM_LAYERS;
  assign id_is_local = cmd_id == LOCAL_LAYER_ID;

  // Write/read command registers shared by all layers.
  logic        wr_q;
  logic [7:0]  wr_id_q;
  logic [23:0] addr_q;
  logic [31:0] wdata_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_q    <= 1'b0;
      wr_id_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      wr_q    <= rule_bus.i_rule_wren && id_is_layer;
      wr_id_q <= cmd_id;
      addr_q  <= rule_bus.i_rule_addr[23:0];
      wdata_q <= rule_bus.i_rule_wdata;
    end
  end

  assign o_layer_addr  = addr_q;
  assign o_layer_wdata = wdata_q;

  // Read FSM state
  rd_state_e          state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [7:0]         rd_id_q, rd_id_d;
  logic               rd_pulse_q, rd_pulse_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rd_err, drop_err;

  logic [31:0] pkt_cnt_q, err_cnt_q;

  always_comb begin
    for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
      o_layer_wren[k] = wr_q && (wr_id_q == 8'(k));
      o_layer_rden[k] = rd_pulse_q && (rd_id_q == 8'(k));
    end
  end

  logic [31:0] local_rdata;
  always_comb begin
    local_rdata = '0;
    case (local_word)
      WORD_VERSION: local_rdata = VERSION;
      WORD_NLAYER:  local_rdata = {24'b0, NL8};
      WORD_PKTCNT:  local_rdata = pkt_cnt_q;
      WORD_ERRCNT:  local_rdata = err_cnt_q;
      default:      local_rdata = '0;
    endcase
  end

  // Only the layer that owns the outstanding read may complete it.
  logic        sel_valid;
  logic [31:0] sel_rdata;
  always_comb begin
    sel_valid = 1'b0;
    sel_rdata = '0;
    for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
      if (rd_id_q == 8'(k)) begin
        sel_valid = i_layer_rdata_valid[k];
        sel_rdata = i_layer_rdata[k];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    rd_id_d    = rd_id_q;
    rd_pulse_d = 1'b0;
    rdata_d    = rdata_q;
    rd_err     = 1'b0;
    drop_err   = rule_bus.i_rule_rden && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (rule_bus.i_rule_rden) begin
          if (id_is_layer) begin
            rd_pulse_d = 1'b1;
            rd_id_d    = cmd_id;
            timer_d    = '0;
            state_d    = WAIT;
          end else if (id_is_local) begin
            rdata_d = local_rdata;
            state_d = RESP;
          end else begin
            rdata_d = BAD_RDATA;
            rd_err  = 1'b1;
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (sel_valid) begin
          rdata_d = sel_rdata;
          state_d = RESP;
        end else if (timer_q == TIMER_LAST) begin
          rdata_d = BAD_RDATA;
          rd_err  = 1'b1;
          state_d = RESP;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      rd_id_q    <= '0;
      rd_pulse_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      rd_id_q    <= rd_id_d;
      rd_pulse_q <= rd_pulse_d;
      rdata_q    <= rdata_d;
    end
  end

  assign rule_bus.o_rule_rdata_valid = state_q == RESP;
  assign rule_bus.o_rule_rdata       = rdata_q;
  assign rule_bus.o_rule_busy        = state_q != IDLE;

  // Counters. Up to three error sources can fire in one cycle
  // (bad write, read error/timeout, dropped read).
  logic       wr_err;
  logic       cnt_clr;
  logic [1:0] err_inc;

  assign wr_err  = rule_bus.i_rule_wren && !id_is_layer && !id_is_local;
  assign cnt_clr = rule_bus.i_rule_wren && id_is_local && (local_word == WORD_ERRCNT);
  assign err_inc = 2'(wr_err) + 2'(rd_err) + 2'(drop_err);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (cnt_clr) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= sat_add(pkt_cnt_q, {1'b0, i_pkt_start});
      err_cnt_q <= sat_add(err_cnt_q, err_inc);
    end
  end

endmodule

// File: rtl/deparser_layer.sv
// Deparser_Layer: one deparser stage.
//   i_rule_*      : layer-internal rule table access (24-bit address, word aligned,
//                   16 words at addr[5:2]); reads answer one cycle later with
//                   o_rule_rdata_valid. Unmapped addresses are not answered.
//   i_head/o_head : head slice + tag, one register stage.
//   i_meta/o_meta : meta + tag, one register stage.
module Deparser_Layer
  import deparser_pkg::*;
(
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_rule_wren,
  input  logic                          i_rule_rden,
  input  logic [23:0]                   i_rule_addr,
  input  logic [31:0]                   i_rule_wdata,
  output logic                          o_rule_rdata_valid,
  output logic [31:0]                   o_rule_rdata,
  input  logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_head,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head,
  input  logic [META_WIDTH+TAG_WIDTH-1:0] i_meta,
  output logic [META_WIDTH+TAG_WIDTH-1:0] o_meta
);

  logic [31:0] rule_mem [16];
  logic        mapped;
  logic [3:0]  idx;

  assign mapped = (i_rule_addr[23:6] == '0) && (i_rule_addr[1:0] == '0);
  assign idx    = i_rule_addr[5:2];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < 16; k++) rule_mem[k] <= '0;
      o_rule_rdata_valid <= 1'b0;
      o_rule_rdata       <= '0;
      o_head             <= '0;
      o_meta             <= '0;
    end else begin
      if (i_rule_wren && mapped) rule_mem[idx] <= i_rule_wdata;
      o_rule_rdata_valid <= i_rule_rden && mapped;
      if (i_rule_rden && mapped) o_rule_rdata <= rule_mem[idx];
      o_head <= i_head;
      o_meta <= i_meta;
    end
  end

endmodule

// File: rtl/deparser_chain.sv
// deparser_chain: NUM_LAYERS Deparser_Layer stages chained head/meta-wise,
// plus the rule bus controller.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   rule_bus       : rule write/read bus (layer ID in addr[31:24], 0xFF = local bank)
//   i_head/o_head  : head slice + tag into layer 0 / out of the last layer
//   i_meta/o_meta  : meta + tag into layer 0 / out of the last layer
module deparser_chain
  import deparser_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 3,
  parameter int unsigned RD_TIMEOUT = 16,
  parameter logic [31:0] VERSION    = 32'h0002_0000
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  deparser_chain_if.slave                 rule_bus,
  input  logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_head,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head,
  input  logic [META_WIDTH+TAG_WIDTH-1:0] i_meta,
  output logic [META_WIDTH+TAG_WIDTH-1:0] o_meta
);

  localparam int unsigned HW = HEAD_WIDTH + TAG_WIDTH;
  localparam int unsigned MW = META_WIDTH + TAG_WIDTH;

  logic [HW-1:0]         head_link [NUM_LAYERS+1];
  logic [MW-1:0]         meta_link [NUM_LAYERS+1];
  logic [NUM_LAYERS-1:0] layer_wren;
  logic [NUM_LAYERS-1:0] layer_rden;
  logic [NUM_LAYERS-1:0] layer_rdata_valid;
  logic [31:0]           layer_rdata [NUM_LAYERS];
  logic [23:0]           layer_addr;
  logic [31:0]           layer_wdata;

  assign head_link[0] = i_head;
  assign meta_link[0] = i_meta;

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
    Deparser_Layer u_layer (
      .i_clk              (i_clk),
      .i_rst_n            (i_rst_n),
      .i_rule_wren        (layer_wren[g]),
      .i_rule_rden        (layer_rden[g]),
      .i_rule_addr        (layer_addr),
      .i_rule_wdata       (layer_wdata),
      .o_rule_rdata_valid (layer_rdata_valid[g]),
      .o_rule_rdata       (layer_rdata[g]),
      .i_head             (head_link[g]),
      .o_head             (head_link[g+1]),
      .i_meta             (meta_link[g]),
      .o_meta             (meta_link[g+1])
    );
  end

  assign o_head = head_link[NUM_LAYERS];
  assign o_meta = meta_link[NUM_LAYERS];

  deparser_rule_ctrl #(
    .NUM_LAYERS (NUM_LAYERS),
    .RD_TIMEOUT (RD_TIMEOUT),
    .VERSION    (VERSION)
  ) u_ctrl (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .rule_bus            (rule_bus),
    .o_layer_wren        (layer_wren),
    .o_layer_rden        (layer_rden),
    .o_layer_addr        (layer_addr),
    .o_layer_wdata       (layer_wdata),
    .i_layer_rdata_valid (layer_rdata_valid),
    .i_layer_rdata       (layer_rdata),
    .i_pkt_start         (o_head[TAG_VALID_BIT] && o_head[TAG_START_BIT])
  );

endmodule

// File: tb/tb_deparser_chain.sv
module tb_deparser_chain;
  import deparser_pkg::*;

  localparam int unsigned NL = 3;
  localparam int unsigned TO = 16;
  localparam int unsigned HW = HEAD_WIDTH + TAG_WIDTH;
  localparam int unsigned MW = META_WIDTH + TAG_WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  deparser_chain_if bus ();
  logic [HW-1:0] head_in, head_out;
  logic [MW-1:0] meta_in, meta_out;

  deparser_chain #(
    .NUM_LAYERS (NL),
    .RD_TIMEOUT (TO),
    .VERSION    (32'h0002_0000)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .rule_bus (bus),
    .i_head   (head_in),
    .o_head   (head_out),
    .i_meta   (meta_in),
    .o_meta   (meta_out)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_err = '0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    bus.i_rule_wren  = 1'b1;
    bus.i_rule_addr  = addr;
    bus.i_rule_wdata = data;
    tick();
    bus.i_rule_wren  = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp, input int lat_exp);
    int          lat;
    int          busy_gaps;
    logic [31:0] want;
    lat       = 1;
    busy_gaps = 0;
    exp_q.push_back(exp);
    bus.i_rule_rden = 1'b1;
    bus.i_rule_addr = addr;
    tick();
    bus.i_rule_rden = 1'b0;
    while (bus.o_rule_rdata_valid !== 1'b1 && lat < 64) begin
      if (bus.o_rule_busy !== 1'b1) busy_gaps++;
      tick();
      lat++;
    end
    if (bus.o_rule_busy !== 1'b1) busy_gaps++;
    check({tag, " latency"}, 128'(lat), 128'(lat_exp));
    want = exp_q.pop_front();
    check({tag, " rdata"}, 128'(bus.o_rule_rdata), 128'(want));
    check({tag, " busy"}, 128'(busy_gaps), 128'(0));
    tick();
    check({tag, " single pulse/idle"},
          128'({bus.o_rule_rdata_valid, bus.o_rule_busy}), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          pulses;
    int          busy_seen;
    logic [HW-1:0] h1;
    logic [MW-1:0] m1;
    logic [31:0] want;

    bus.i_rule_wren  = 1'b0;
    bus.i_rule_rden  = 1'b0;
    bus.i_rule_addr  = '0;
    bus.i_rule_wdata = '0;
    head_in = '0;
    meta_in = '0;
    rst_n   = 1'b0;
    repeat (3) tick();

    check("reset valid", 128'(bus.o_rule_rdata_valid), 128'(0));
    check("reset busy",  128'(bus.o_rule_busy), 128'(0));
    check("reset rdata", 128'(bus.o_rule_rdata), 128'(0));
    check("reset head",  128'(head_out), 128'(0));
    check("reset meta",  128'(meta_out), 128'(0));

    rst_n = 1'b1;
    tick();

    // Layer write routing and read-back
    do_write(32'h0100_0010, 32'h0000_1234);
    check("wr l1 strobe", 128'(dut.layer_wren), 128'(3'b010));
    tick();
    check("wr l1 strobe end", 128'(dut.layer_wren), 128'(0));
    do_read("rd l1", 32'h0100_0010, 32'h0000_1234, 3);

    do_write(32'h0200_0004, 32'hA5A5_0F0F);
    check("wr l2 strobe", 128'(dut.layer_wren), 128'(3'b100));
    tick();
    do_read("rd l2", 32'h0200_0004, 32'hA5A5_0F0F, 3);
    do_read("rd l0 untouched", 32'h0000_0004, 32'h0, 3);

    // Local bank
    do_read("nlayer",  32'hFF00_0004, 32'(NL), 1);
    do_read("version", 32'hFF00_0000, 32'h0002_0000, 1);

    // Invalid layer ID read
    do_read("bad id", 32'h0700_0000, BAD_RDATA, 1);
    exp_err++;
    do_read("err after bad id", 32'hFF00_000C, exp_err, 1);

    // Invalid ID write, then write to a read-only local word
    do_write(32'h0500_0000, 32'h0000_FFFF);
    exp_err++;
    check("bad wr no strobe", 128'(dut.layer_wren), 128'(0));
    tick();
    do_write(32'hFF00_0000, 32'h0);
    tick();
    do_read("version after ro write", 32'hFF00_0000, 32'h0002_0000, 1);
    do_read("err after bad wr", 32'hFF00_000C, exp_err, 1);

    // Timeout on an unanswered layer address, with a dropped read in WAIT
    exp_q.push_back(BAD_RDATA);
    bus.i_rule_rden = 1'b1;
    bus.i_rule_addr = 32'h0000_1000;
    tick();
    bus.i_rule_rden = 1'b0;
    lat = 1;
    check("timeout busy", 128'(bus.o_rule_busy), 128'(1));
    repeat (4) tick();
    lat += 4;
    bus.i_rule_rden = 1'b1;
    bus.i_rule_addr = 32'hFF00_0000;
    tick();
    bus.i_rule_rden = 1'b0;
    lat++;
    exp_err++;
    while (bus.o_rule_rdata_valid !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
    check("timeout latency", 128'(lat), 128'(TO + 1));
    want = exp_q.pop_front();
    check("timeout rdata", 128'(bus.o_rule_rdata), 128'(want));
    exp_err++;
    tick();
    check("timeout single pulse", 128'(bus.o_rule_rdata_valid), 128'(0));
    do_read("err after timeout", 32'hFF00_000C, exp_err, 1);

    // Three two-slice packets; head/meta pass through NL stages
    for (int p = 0; p < 3; p++) begin
      h1 = {56'(32'hC0DE_0000 + 32'(p)), 8'h03};
      m1 = {32'(32'h5EED_0000 + 32'(p)), 8'h03};
      head_in = h1;
      meta_in = m1;
      tick();
      head_in = {56'(32'hB0D1_0000 + 32'(p)), 8'h01};
      meta_in = {32'h0, 8'h01};
      tick();
      head_in = '0;
      meta_in = '0;
      tick();
      check("head chain", 128'(head_out), 128'(h1));
      check("meta chain", 128'(meta_out), 128'(m1));
    end
    repeat (NL) tick();
    do_read("pkt cnt", 32'hFF00_0008, 32'd3, 1);

    // Clear both counters
    do_write(32'hFF00_000C, 32'h0);
    tick();
    exp_err = '0;
    do_read("pkt cnt cleared", 32'hFF00_0008, 32'd0, 1);
    do_read("err cnt cleared", 32'hFF00_000C, exp_err, 1);

    // Reset during WAIT aborts the read silently
    bus.i_rule_rden = 1'b1;
    bus.i_rule_addr = 32'h0000_1000;
    tick();
    bus.i_rule_rden = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    pulses    = 0;
    busy_seen = 0;
    for (int i = 0; i < TO + 8; i++) begin
      if (bus.o_rule_rdata_valid !== 1'b0) pulses++;
      if (bus.o_rule_busy !== 1'b0) busy_seen++;
      tick();
    end
    check("abort no pulse", 128'(pulses), 128'(0));
    check("abort not busy", 128'(busy_seen), 128'(0));

    do_write(32'h0200_0008, 32'hCAFE_0001);
    tick();
    do_read("rd after abort", 32'h0200_0008, 32'hCAFE_0001, 3);
    do_read("err after abort", 32'hFF00_000C, 32'h0, 1);

    check("scoreboard drained", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/deparser_chain.md
Name: deparser_chain

Overview:
- Parametrised successor of the fixed three-layer deparser top. Chains NUM_LAYERS Deparser_Layer instances in a generate loop: head/meta flow layer 0 -> NUM_LAYERS-1.
- Adds routed rule readback with a single-outstanding read FSM and a timeout. Adds a local status/counter register bank at layer ID 0xFF.
- Sits between the parser pipeline output and the egress packet assembler.

Parameters:
- NUM_LAYERS, 3, number of chained Deparser_Layer instances (1..254).
- RD_TIMEOUT, 16, cycles to wait for a layer read response before error completion (>=2).
- VERSION, 32'h0002_0000, value returned at local word 0.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_rule_wren  in  1  rule write strobe.
- i_rule_rden  in  1  rule read strobe.
- i_rule_addr  in  32  [31:24] layer ID (0xFF = local bank); [23:0] layer-internal address.
- i_rule_wdata  in  32  write data.
- o_rule_rdata_valid  out  1  one-cycle read-completion pulse.
- o_rule_rdata  out  32  read data, valid with o_rule_rdata_valid.
- o_rule_busy  out  1  read in flight; new reads are rejected.
- i_head  in  `HEAD_WIDTH+`TAG_WIDTH  head slice plus tag into layer 0.
- o_head  out  `HEAD_WIDTH+`TAG_WIDTH  head from the last layer.
- i_meta  in  `META_WIDTH+`TAG_WIDTH  meta plus tag into layer 0.
- o_meta  out  `META_WIDTH+`TAG_WIDTH  meta from the last layer.

Behaviour:
- Reset: all outputs of this block 0; FSM IDLE; counters 0; registered write/read strobes 0. Data path reset is owned by the layers.
- Data path: pure chain, no added latency. o_head/o_meta equal the last layer outputs.
- Writes, layer IDs 0..NUM_LAYERS-1: addr/wdata/wren registered once and presented to the selected layer only, 1 cycle after i_rule_wren.
- Write to local bank: word 3 (addr[3:2]=3) clears both counters; other local words are read-only and the write is ignored.
- Write to any other ID: ignored, ERR_CNT++.
- Read FSM states IDLE, WAIT, RESP.
  - IDLE + rden, valid layer ID: registered rden pulse to that layer next cycle; go to WAIT with timer=0 in that cycle.
  - IDLE + rden, ID 0xFF: capture local word; go to RESP.
  - IDLE + rden, other ID: capture 32'hDEADBEEF; ERR_CNT++; go to RESP.
  - WAIT + selected layer's rdata_valid: capture its rdata; go to RESP.
  - WAIT, timer==RD_TIMEOUT-1 with no response: capture 32'hDEADBEEF; ERR_CNT++; go to RESP.
  - RESP: o_rule_rdata_valid=1 for exactly one cycle; return to IDLE.
- Latency: a local or invalid read issued in cycle T completes in cycle T+1. A layer read completes 1 cycle after the layer's response.
- o_rule_busy = (state != IDLE). Asserted the cycle after rden is accepted.
- rden while busy: dropped, ERR_CNT++, in-flight read unaffected.
- Layer rdata_valid outside WAIT, or from a non-selected layer: ignored.
- wren and rden in the same cycle: both processed independently. A write to the layer being read is allowed.
- Local words (addr[3:2]):
  - 0 = VERSION.
  - 1 = {24'b0, NUM_LAYERS[7:0]}.
  - 2 = PKT_CNT: increments when o_head has TAG_VALID_BIT and TAG_START_BIT set.
  - 3 = ERR_CNT.
- Both counters are 32-bit and saturate at 32'hFFFF_FFFF. A clear in the same cycle as an increment wins (result 0).
- Reset mid-read: FSM returns to IDLE; no completion pulse is issued for the aborted read.

Decomposition:
- Package deparser_pkg:
  - LOCAL_LAYER_ID = 8'hFF, BAD_RDATA = 32'hDEADBEEF.
  - Local word indices WORD_VERSION/WORD_NLAYER/WORD_PKTCNT/WORD_ERRCNT.
  - typedef enum rd_state_e {IDLE, WAIT, RESP}.
- Sub-module deparser_rule_ctrl: address decode, write registering, read FSM, timeout timer, counters.
- The top holds only the generate-loop chain of Deparser_Layer plus deparser_rule_ctrl.

Test Plan:
- Write addr 0x0100_0010/data 0x1234 -> only layer 1 sees wren, one cycle later. Read the same address -> rdata 0x1234 with a single valid pulse, busy high throughout.
- Read 0xFF00_0004 with NUM_LAYERS=5 -> rdata 0x0000_0005 one cycle after rden. Read 0xFF00_0000 -> 0x0002_0000.
- Read 0x0700_0000 (ID 7, NUM_LAYERS=3) -> 0xDEADBEEF next cycle; ERR_CNT reads 1.
- Stub layer that never answers, RD_TIMEOUT=16 -> 0xDEADBEEF exactly 16 cycles after layer rden. A second rden during WAIT is dropped; ERR_CNT=2.
- Drive 3 packets (valid+start on the first slice each) -> PKT_CNT=3. Write local word 3 -> PKT_CNT=0 and ERR_CNT=0.
- Assert i_rst_n=0 for one cycle during WAIT -> no valid pulse, busy 0. A later read completes normally.
